// File: rtl/parking_pkg.sv
// Shared types and constants for the parking payment controller:
// FSM state encoding, coin codes with their decoded values, and money width.
package parking_pkg;

    localparam int COST_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COLLECT,
        ST_GATE,
        ST_ABORT
    } state_e;

    localparam logic [1:0] COIN_CODE_1  = 2'b00;
    localparam logic [1:0] COIN_CODE_5  = 2'b01;
    localparam logic [1:0] COIN_CODE_10 = 2'b10;
    localparam logic [1:0] COIN_CODE_25 = 2'b11;

    localparam logic [COST_W-1:0] COIN_VAL_1  = 10'd1;
    localparam logic [COST_W-1:0] COIN_VAL_5  = 10'd5;
    localparam logic [COST_W-1:0] COIN_VAL_10 = 10'd10;
    localparam logic [COST_W-1:0] COIN_VAL_25 = 10'd25;

    // Translate a coin code into its monetary value.
    function automatic logic [COST_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_CODE_1:  coin_value = COIN_VAL_1;
            COIN_CODE_5:  coin_value = COIN_VAL_5;
            COIN_CODE_10: coin_value = COIN_VAL_10;
            default:      coin_value = COIN_VAL_25;
        endcase
    endfunction

endpackage

// File: rtl/parking_payment_ctrl_gate_timer.sv
// Loadable down-counter with a zero flag; it times how long the exit gate
// stays open after a settlement.
module gate_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load takes priority over a decrement; the counter never
    // goes below zero.
    always_comb begin
        // NOTE: assign every combinational output a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/parking_payment_ctrl.sv
// Exit payment controller: latches the exiting car's cost, accumulates coins,
// opens the gate with change on full payment, or aborts with a refund when the
// driver stops inserting coins.
module parking_payment_ctrl
    import parking_pkg::*;
#(
    parameter int GATE_CYCLES = 8,
    parameter int PAY_TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exit_req,
    input  logic [2:0]        exit_sel,
    input  logic [COST_W-1:0] cost_in,
    input  logic              coin_valid,
    input  logic [1:0]        coin_code,
    output logic              busy,
    output logic [COST_W-1:0] amount_due,
    output logic [COST_W-1:0] amount_paid,
    output logic [COST_W-1:0] change_out,
    output logic              gate_open,
    output logic [2:0]        active_sel,
    output logic              done,
    output logic              abort,
    output logic [COST_W-1:0] refund
);

    // Timeout counter only has to reach PAY_TIMEOUT-1.
    localparam int TMO_W = (PAY_TIMEOUT > 2) ? $clog2(PAY_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PAY_TIMEOUT - 1);

    // Gate timer is loaded with GATE_CYCLES-1 and the gate closes after the
    // cycle in which it reads zero, giving exactly GATE_CYCLES open cycles.
    localparam int GT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GT_W-1:0] GT_LOAD = GT_W'(GATE_CYCLES - 1);

    state_e            state_q,      state_d;
    logic [2:0]        active_sel_q, active_sel_d;
    logic [COST_W-1:0] due_q,        due_d;
    logic [COST_W-1:0] paid_q,       paid_d;
    logic [COST_W-1:0] change_q,     change_d;
    logic [TMO_W-1:0]  tmo_q,        tmo_d;
    logic              done_q,       done_d;

    logic              sel_valid;
    logic [COST_W:0]   coin_sum;
    logic [COST_W-1:0] paid_sat;
    logic              timer_load;
    logic              timer_dec;
    logic              timer_zero;

    assign sel_valid = (exit_sel != 3'd0) && (exit_sel <= 3'd3);

    // Coin accumulation with one spare bit to detect overflow, clamped to the
    // largest representable amount instead of wrapping.
    assign coin_sum = {1'b0, paid_q} + {1'b0, coin_value(coin_code)};
    assign paid_sat = coin_sum[COST_W] ? '1 : coin_sum[COST_W-1:0];

    // Next-state and datapath updates for the settlement sequence.
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        due_d        = due_q;
        paid_d       = paid_q;
        change_d     = change_q;
        tmo_d        = tmo_q;
        done_d       = 1'b0;
        timer_load   = 1'b0;
        timer_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (exit_req && sel_valid) begin
                    active_sel_d = exit_sel;
                    state_d      = ST_LOAD;
                end
            end

            ST_LOAD: begin
                due_d  = cost_in;
                paid_d = '0;
                tmo_d  = '0;
                if (cost_in == '0) begin
                    // Nothing owed: settle at once with zero change.
                    change_d   = '0;
                    done_d     = 1'b1;
                    timer_load = 1'b1;
                    state_d    = ST_GATE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (coin_valid) begin
                    // A coin always restarts the idle count, even in the
                    // cycle that would otherwise have timed out.
                    paid_d = paid_sat;
                    tmo_d  = '0;
                    if (paid_sat >= due_q) begin
                        change_d   = paid_sat - due_q;
                        done_d     = 1'b1;
                        timer_load = 1'b1;
                        state_d    = ST_GATE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ABORT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_GATE: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            ST_ABORT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset clears every one of them, which also
    // closes the gate immediately since gate_open decodes the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            active_sel_q <= '0;
            due_q        <= '0;
            paid_q       <= '0;
            change_q     <= '0;
            tmo_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            due_q        <= due_d;
            paid_q       <= paid_d;
            change_q     <= change_d;
            tmo_q        <= tmo_d;
            done_q       <= done_d;
        end
    end

    gate_timer #(
        .W (GT_W)
    ) u_gate_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (GT_LOAD),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    assign busy        = (state_q != ST_IDLE);
    assign gate_open   = (state_q == ST_GATE);
    assign abort       = (state_q == ST_ABORT);
    assign refund      = abort ? paid_q : '0;
    assign done        = done_q;
    assign amount_due  = due_q;
    assign amount_paid = paid_q;
    assign change_out  = change_q;
    assign active_sel  = active_sel_q;

endmodule
